// File: rtl/elevador_pkg.sv
// rtl/elevador_pkg.sv - shared direction and mode constants for the elevator datapath
package elevador_pkg;
   localparam logic SOBE          = 1'b0;
   localparam logic DESCE         = 1'b1;
   localparam logic MODO_CIRCULAR = 1'b0;
   localparam logic MODO_SATURA   = 1'b1;
endpackage

// File: rtl/comparador_alvo.sv
// rtl/comparador_alvo.sv - unsigned three-way compare of a count against a target floor
module comparador_alvo #(
   parameter int N = 4
) (
   input  logic [N-1:0] q,
   input  logic [N-1:0] alvo,
   output logic         igual,
   output logic         acima,
   output logic         abaixo
);
   always_comb begin
      igual  = (q == alvo);
      acima  = (q >  alvo);
      abaixo = (q <  alvo);
   end
endmodule

// File: rtl/contador_ud_p.sv
// rtl/contador_ud_p.sv - up/down modulo-M counter with load, wrap/saturate mode and boundary pulse
module contador_ud_p
   import elevador_pkg::*;
#(
   parameter int M      = 16,
   parameter int N      = 4,
   parameter bit SATURA = MODO_CIRCULAR
) (
   input  logic         clock,
   input  logic         zera_as_n,
   input  logic         zera_s,
   input  logic         carrega,
   input  logic [N-1:0] D,
   input  logic         conta,
   input  logic         desce,
   input  logic [N-1:0] alvo,
   output logic [N-1:0] Q,
   output logic         fim,
   output logic         inicio,
   output logic         meio,
   output logic         estouro,
   output logic         igual,
   output logic         acima,
   output logic         abaixo
);
   localparam logic [N-1:0] Q_MAX  = N'(M - 1);
   localparam logic [N-1:0] Q_MEIO = N'(M / 2 - 1);

   logic [N-1:0] q_q, q_d;
   logic         estouro_q, estouro_d;

   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         q_q       <= '0;
         estouro_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         estouro_q <= estouro_d;
      end
   end

   // Boundary events assert estouro whether the count wraps or holds.
   always_comb begin
      q_d       = q_q;
      estouro_d = 1'b0;
      if (zera_s) begin
         q_d = '0;
      end else if (carrega) begin
         q_d = (D > Q_MAX) ? Q_MAX : D;
      end else if (conta) begin
         if (desce == SOBE) begin
            if (q_q < Q_MAX) begin
               q_d = q_q + 1'b1;
            end else begin
               estouro_d = 1'b1;
               if (SATURA == MODO_CIRCULAR) q_d = '0;
            end
         end else begin
            if (q_q != '0) begin
               q_d = q_q - 1'b1;
            end else begin
               estouro_d = 1'b1;
               if (SATURA == MODO_CIRCULAR) q_d = Q_MAX;
            end
         end
      end
   end

   always_comb begin
      Q       = q_q;
      estouro = estouro_q;
      fim     = (q_q == Q_MAX);
      inicio  = (q_q == '0);
      meio    = (q_q == Q_MEIO);
   end

   comparador_alvo #(.N(N)) u_comparador (
      .q      (q_q),
      .alvo   (alvo),
      .igual  (igual),
      .acima  (acima),
      .abaixo (abaixo)
   );
endmodule
